// File: rtl/sensors_height_filter.sv
// Purpose : averages the non-zero opposing sensor pairs of one snapshot, rounds
//           half-up with a serial restoring divider, and smooths the result
//           over a DEPTH-entry moving average; a snapshot with no usable pair
//           raises a fault pulse instead.
// Latency : out_valid NPAIR+SW+2 edges after the accepting edge, fault NPAIR+1.
// Backpr. : one snapshot in flight; in_ready is high only in IDLE, so the
//           source holds its snapshot while the block is busy.
// Ports   : clk/rst (sync, active-high) | in_valid/in_ready + sensors (flat,
//           sensor i at [(i+1)*W-1:i*W]) | raw_height, height, out_valid, fault.
module sensors_height_filter #(
   parameter int W     = 8,
   parameter int NPAIR = 2,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*NPAIR*W-1:0] sensors,
   output logic [W-1:0]         raw_height,
   output logic [W-1:0]         height,
   output logic                 out_valid,
   output logic                 fault
);

   localparam int SW   = W + $clog2(2*NPAIR);      // pair-sum / dividend width
   localparam int NW   = $clog2(2*NPAIR + 1);      // reading-count width
   localparam int LD   = $clog2(DEPTH);
   localparam int RW   = W + LD;                   // running-sum width
   localparam int PW   = (DEPTH > 1) ? LD : 1;
   localparam int CMAX = (SW > NPAIR) ? SW : NPAIR;
   localparam int CW   = $clog2(CMAX + 1) + 1;
   localparam logic [CW-1:0] C_SCAN_LAST = CW'(NPAIR - 1);
   localparam logic [CW-1:0] C_DIV_LAST  = CW'(SW);

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DIV, S_AVG, S_FLT} state_t;

   state_t                 r_state, w_state_nxt;
   logic [2*NPAIR*W-1:0]   r_sens;
   logic [SW-1:0]          r_sum, r_dvd, r_rem;
   logic [NW-1:0]          r_n;
   logic [CW-1:0]          r_cnt;
   logic [W-1:0]           r_quo, r_raw, r_height;
   logic [W-1:0]           r_win [DEPTH];
   logic [PW-1:0]          r_ptr;
   logic [RW-1:0]          r_runsum;
   logic                   r_first, r_out_valid, r_fault;

   logic [W-1:0]           w_sa, w_sb;
   logic                   w_pair_ok;
   logic [SW:0]            w_trial;
   logic                   w_qbit;
   logic [SW-1:0]          w_rem_nxt;
   logic [RW-1:0]          w_runsum_nxt, w_hgt_rnd;

   // Pair under examination during SCAN is selected by r_cnt.
   always_comb begin
      w_sa = '0;
      w_sb = '0;
      for (int p = 0; p < NPAIR; p++) begin
         if (r_cnt == CW'(p)) begin
            w_sa = r_sens[p*W +: W];
            w_sb = r_sens[(p+NPAIR)*W +: W];
         end
      end
      w_pair_ok = (w_sa != '0) && (w_sb != '0);
   end

   // One restoring-division step: bring down the dividend MSB, subtract if it fits.
   always_comb begin
      w_trial   = {r_rem, r_dvd[SW-1]};
      w_qbit    = (w_trial >= (SW+1)'(r_n));
      w_rem_nxt = w_qbit ? SW'(w_trial - (SW+1)'(r_n)) : w_trial[SW-1:0];
   end

   // First good sample preloads every window entry, so the sum is raw*DEPTH.
   always_comb begin
      w_runsum_nxt = r_first ? (RW'(r_quo) << LD)
                             : (r_runsum - RW'(r_win[r_ptr]) + RW'(r_quo));
      w_hgt_rnd    = w_runsum_nxt + RW'(DEPTH/2);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic. The zero-pair decision uses the last pair's result
   // combinationally so a fault leaves SCAN without an extra cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_state_nxt = S_SCAN;
         S_SCAN: if (r_cnt == C_SCAN_LAST)
                    w_state_nxt = (w_pair_ok || (r_n != '0)) ? S_DIV : S_FLT;
         S_DIV:  if (r_cnt == C_DIV_LAST) w_state_nxt = S_AVG;
         S_AVG:  w_state_nxt = S_IDLE;
         S_FLT:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready = (r_state == S_IDLE);
   end

   assign raw_height = r_raw;
   assign height     = r_height;
   assign out_valid  = r_out_valid;
   assign fault      = r_fault;

   // Datapath. DIV spends its first cycle (r_cnt==0) loading the rounded
   // dividend, then produces one quotient bit per cycle for SW cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sens      <= '0;
         r_sum       <= '0;
         r_dvd       <= '0;
         r_rem       <= '0;
         r_n         <= '0;
         r_cnt       <= '0;
         r_quo       <= '0;
         r_raw       <= '0;
         r_height    <= '0;
         r_ptr       <= '0;
         r_runsum    <= '0;
         r_first     <= 1'b1;
         r_out_valid <= 1'b0;
         r_fault     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
      end else begin
         r_out_valid <= 1'b0;
         r_fault     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_sens <= sensors;
                  r_sum  <= '0;
                  r_n    <= '0;
                  r_cnt  <= '0;
               end
            end
            S_SCAN: begin
               if (w_pair_ok) begin
                  r_sum <= r_sum + SW'(w_sa) + SW'(w_sb);
                  r_n   <= r_n + NW'(2);
               end
               r_cnt <= (r_cnt == C_SCAN_LAST) ? '0 : r_cnt + CW'(1);
            end
            S_DIV: begin
               if (r_cnt == '0) begin
                  r_dvd <= r_sum + SW'(r_n >> 1);
                  r_rem <= '0;
                  r_quo <= '0;
               end else begin
                  r_rem <= w_rem_nxt;
                  r_dvd <= {r_dvd[SW-2:0], 1'b0};
                  r_quo <= {r_quo[W-2:0], w_qbit};
               end
               r_cnt <= r_cnt + CW'(1);
            end
            S_AVG: begin
               if (r_first) begin
                  for (int i = 0; i < DEPTH; i++) r_win[i] <= r_quo;
               end else begin
                  r_win[r_ptr] <= r_quo;
                  r_ptr <= (r_ptr == PW'(DEPTH-1)) ? '0 : r_ptr + PW'(1);
               end
               r_runsum    <= w_runsum_nxt;
               r_raw       <= r_quo;
               r_height    <= W'(w_hgt_rnd >> LD);
               r_first     <= 1'b0;
               r_out_valid <= 1'b1;
            end
            S_FLT: begin
               r_fault <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sensors_height_filter.sv
module tb_sensors_height_filter;

   localparam int W      = 8;
   localparam int NPAIR  = 2;
   localparam int DEPTH  = 4;
   localparam int NS     = 2*NPAIR;
   localparam int SNS_W  = NS*W;
   localparam int SW     = W + $clog2(2*NPAIR);
   localparam int L      = NPAIR + SW + 2;
   localparam int FLTLAT = NPAIR + 1;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [SNS_W-1:0] sensors;
   logic [W-1:0]     raw_height;
   logic [W-1:0]     height;
   logic             out_valid;
   logic             fault;

   sensors_height_filter #(.W(W), .NPAIR(NPAIR), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sensors    (sensors),
      .raw_height (raw_height),
      .height     (height),
      .out_valid  (out_valid),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state: last good raw, current height, window contents.
   int exp_raw;
   int exp_height;
   bit exp_fault;
   bit mdl_first;
   int win_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_raw    = 0;
      exp_height = 0;
      exp_fault  = 0;
      mdl_first  = 1;
      win_q.delete();
   endtask

   // Mean of readings from pairs with no zero, rounded half-up; then the
   // rounded mean of the last DEPTH good samples.
   task automatic model_apply(input logic [SNS_W-1:0] v);
      int s[NS];
      int sum, n, tot;
      for (int i = 0; i < NS; i++) s[i] = int'(v[i*W +: W]);
      sum = 0;
      n   = 0;
      for (int p = 0; p < NPAIR; p++) begin
         if (s[p] != 0 && s[p+NPAIR] != 0) begin
            sum += s[p] + s[p+NPAIR];
            n   += 2;
         end
      end
      if (n == 0) begin
         exp_fault = 1;
      end else begin
         exp_fault = 0;
         exp_raw   = (sum + n/2) / n;
         if (mdl_first) begin
            for (int i = 0; i < DEPTH; i++) win_q.push_back(exp_raw);
            mdl_first = 0;
         end else begin
            win_q.push_back(exp_raw);
            void'(win_q.pop_front());
         end
         tot = 0;
         foreach (win_q[i]) tot += win_q[i];
         exp_height = (tot + DEPTH/2) / DEPTH;
      end
   endtask

   function automatic logic [SNS_W-1:0] pack4(input int a, input int b, input int c, input int d);
      logic [SNS_W-1:0] r;
      r = {W'(d), W'(c), W'(b), W'(a)};
      return r;
   endfunction

   function automatic logic [SNS_W-1:0] rand_snap();
      logic [SNS_W-1:0] r;
      r = '0;
      for (int i = 0; i < NS; i++)
         r[i*W +: W] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, (1 << W) - 1));
      return r;
   endfunction

   task automatic check_result(input string pfx);
      check({pfx, "_fault"}, fault, exp_fault);
      check({pfx, "_ovld"}, out_valid, !exp_fault);
      check({pfx, "_raw"}, raw_height, exp_raw);
      check({pfx, "_hgt"}, height, exp_height);
      check({pfx, "_rdy"}, in_ready, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1;
      in_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdy", in_ready, 1'b1);
      check("rst_ovld", out_valid, 1'b0);
      check("rst_fault", fault, 1'b0);
      check("rst_raw", raw_height, 0);
      check("rst_hgt", height, 0);
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   // One snapshot: wait for ready, present it for the accepting edge, then
   // scramble the bus to show the registered copy is what gets used.
   task automatic send(input logic [SNS_W-1:0] v);
      int k;
      int lat;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1; k++;
      end
      check("send_rdy", in_ready, 1'b1);
      @(negedge clk);
      sensors  = v;
      in_valid = 1;
      @(posedge clk);
      #1;
      in_valid = 0;
      sensors  = SNS_W'($urandom);
      model_apply(v);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (out_valid || fault) begin
            lat = i;
            break;
         end
      end
      check("lat", lat, exp_fault ? FLTLAT : L);
      check_result("snd");
      @(posedge clk); #1;
      check("pulse_width", out_valid | fault, 1'b0);
   endtask

   // in_valid held high with data changing every cycle: only the value present
   // on an edge with in_ready=1 counts, and accepts follow pulses back to back.
   task automatic stream(input int count);
      int acc = 0;
      int age = 0;
      int cyc = 0;
      int last_pulse = -10;
      bit busy = 0;
      logic rdy;
      logic [SNS_W-1:0] v;
      while (acc < count || busy) begin
         if (cyc > count*40 + 100) begin
            check("stream_timeout", 1'b1, 1'b0);
            break;
         end
         @(negedge clk);
         v        = rand_snap();
         sensors  = v;
         in_valid = (acc < count);
         rdy      = in_ready;
         @(posedge clk);
         cyc++;
         if (busy) check("rdy_busy", rdy, 1'b0);
         if (rdy && in_valid) begin
            if (acc > 0) check("b2b", cyc, last_pulse + 1);
            model_apply(v);
            busy = 1;
            age  = 0;
            acc++;
         end else if (busy) begin
            age++;
         end
         #1;
         if (out_valid || fault) begin
            if (!busy) begin
               check("spurious", 1'b1, 1'b0);
            end else begin
               check("s_lat", age, exp_fault ? FLTLAT : L);
               check("s_excl", out_valid & fault, 1'b0);
               check_result("str");
               busy       = 0;
               last_pulse = cyc;
            end
         end
      end
      @(negedge clk);
      in_valid = 0;
   endtask

   initial begin
      int pulses;
      clk      = 0;
      rst      = 1;
      in_valid = 0;
      sensors  = '0;
      model_reset();

      do_reset();
      send(pack4(10, 11, 12, 13));
      send(pack4(0, 7, 12, 8));
      send(pack4(0, 0, 0, 0));
      send(pack4(0, 5, 9, 0));
      send(pack4(30, 31, 29, 33));

      // Window wrap
      do_reset();
      send(pack4(20, 20, 20, 20));
      for (int i = 0; i < 4; i++) send(pack4(40, 40, 40, 40));

      stream(25);

      // Reset in the middle of the division
      while (!in_ready) begin @(posedge clk); #1; end
      @(negedge clk);
      sensors  = pack4(10, 11, 12, 13);
      in_valid = 1;
      @(posedge clk);
      #1;
      in_valid = 0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      check("mid_rdy", in_ready, 1'b1);
      check("mid_ovld", out_valid, 1'b0);
      check("mid_raw", raw_height, 0);
      check("mid_hgt", height, 0);
      @(negedge clk);
      rst = 0;
      model_reset();
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid || fault) pulses++;
      end
      check("mid_nopulse", pulses, 0);
      send(pack4(255, 255, 255, 255));

      stream(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
